bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 100 ++++++++++
 tb/tb_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that shares one memory port between an I-cache refill port and a data port
//   i_clk, i_rst                  clock (rising edge), synchronous active-high reset
//   i_ic_req/i_ic_addr            I-cache refill read request (level) and word address
//   o_ic_ready/o_ic_rdata         I-cache done pulse and read data
//   i_dm_rd/i_dm_wen              data read/write requests (level), write wins when both set
//   i_dm_addr/i_dm_wd/i_dm_f3     data address, write data, funct3
//   o_dm_ready/o_dm_rdata         data done pulse and read data
//   o_mem_*                       shared memory strobes, address, write data, funct3
//   i_mem_ready/i_mem_rdata       memory completion and read data
//   o_busy/o_grant_dm/o_timeout   transaction in progress, data port owns bus, forced-completion pulse
module bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ic_req,
    input  logic [XLEN-1:0] i_ic_addr,
    output logic            o_ic_ready,
    output logic [XLEN-1:0] o_ic_rdata,
    input  logic            i_dm_rd,
    input  logic            i_dm_wen,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wd,
    input  logic [2:0]      i_dm_f3,
    output logic            o_dm_ready,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_mem_rd,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wd,
    output logic [2:0]      o_mem_f3,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_busy,
    output logic            o_grant_dm,
    output logic            o_timeout
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, IC_BUSY, DM_BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_dm_q, last_dm_d;
    logic          dm_req, ic_act, dm_act, live, expire, done;

    assign dm_req = i_dm_rd | i_dm_wen;
    // A grant is live only while its owner keeps requesting; reset kills it in the same cycle
    assign ic_act = ~i_rst & (state_q == IC_BUSY) & i_ic_req;
    assign dm_act = ~i_rst & (state_q == DM_BUSY) & dm_req;
    assign live   = ic_act | dm_act;
    // Memory completion in the last allowed cycle beats the timeout
    assign expire = (TIMEOUT > 0) & live & ~i_mem_ready & (cnt_q == CW'(TIMEOUT - 1));
    assign done   = live & (i_mem_ready | expire);

    assign o_mem_rd   = ic_act | (dm_act & i_dm_rd & ~i_dm_wen);
    assign o_mem_wen  = dm_act & i_dm_wen;
    assign o_mem_addr = ic_act ? i_ic_addr : dm_act ? i_dm_addr : '0;
    assign o_mem_wd   = dm_act ? i_dm_wd : '0;
    assign o_mem_f3   = ic_act ? 3'b010 : dm_act ? i_dm_f3 : 3'b000;
    assign o_ic_ready = ic_act & done;
    assign o_dm_ready = dm_act & done;
    assign o_ic_rdata = (ic_act & expire) ? '0 : i_mem_rdata;
    assign o_dm_rdata = (dm_act & expire) ? '0 : i_mem_rdata;
    assign o_timeout  = expire;
    assign o_busy     = state_q != IDLE;
    assign o_grant_dm = state_q == DM_BUSY;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        last_dm_d = last_dm_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            // On a tie the port that did not win last time is granted
            if (i_ic_req && (!dm_req || last_dm_q)) begin
                state_d   = IC_BUSY;
                last_dm_d = 1'b0;
            end else if (dm_req) begin
                state_d   = DM_BUSY;
                last_dm_d = 1'b1;
            end
        end else if (!live || done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_dm_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_dm_q <= last_dm_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and random checks of bus_arbiter against a transaction-level reference model
module tb_bus_arbiter;
    localparam int TO = 4;

    logic        i_clk;
    logic        rst, ic_req, dm_rd, dm_wen, mem_ready;
    logic [31:0] ic_addr, dm_addr, dm_wd, mem_rdata;
    logic [2:0]  dm_f3;
    logic        o_ic_ready, o_dm_ready, o_mem_rd, o_mem_wen, o_busy, o_grant_dm, o_timeout;
    logic [31:0] o_ic_rdata, o_dm_rdata, o_mem_addr, o_mem_wd;
    logic [2:0]  o_mem_f3;

    int n_asserts = 0;
    int n_fail    = 0;
    int owner     = 0;
    int age       = 0;
    bit prefer_ic = 1;

    bus_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(rst),
        .i_ic_req(ic_req), .i_ic_addr(ic_addr), .o_ic_ready(o_ic_ready), .o_ic_rdata(o_ic_rdata),
        .i_dm_rd(dm_rd), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wd(dm_wd), .i_dm_f3(dm_f3),
        .o_dm_ready(o_dm_ready), .o_dm_rdata(o_dm_rdata),
        .o_mem_rd(o_mem_rd), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr), .o_mem_wd(o_mem_wd),
        .o_mem_f3(o_mem_f3), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
        .o_busy(o_busy), .o_grant_dm(o_grant_dm), .o_timeout(o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Owner: 0 none, 1 I-cache, 2 data port; age counts completed BUSY cycles of the current transfer
    task automatic step();
        bit live, expire, fin;
        #1;
        live   = !rst && ((owner == 1 && ic_req) || (owner == 2 && (dm_rd || dm_wen)));
        expire = live && TO > 0 && age == TO - 1 && !mem_ready;
        fin    = live && (mem_ready || expire);
        chk("busy", o_busy, owner != 0);
        chk("grant_dm", o_grant_dm, owner == 2);
        chk("mem_rd", o_mem_rd, live && (owner == 1 || (dm_rd && !dm_wen)));
        chk("mem_wen", o_mem_wen, live && owner == 2 && dm_wen);
        if (live) begin
            chk("mem_addr", o_mem_addr, owner == 1 ? ic_addr : dm_addr);
            chk("mem_wd", o_mem_wd, owner == 1 ? 32'h0 : dm_wd);
            chk("mem_f3", o_mem_f3, owner == 1 ? 3'b010 : dm_f3);
        end
        chk("ic_ready", o_ic_ready, fin && owner == 1);
        chk("dm_ready", o_dm_ready, fin && owner == 2);
        chk("timeout", o_timeout, expire);
        chk("ic_rdata", o_ic_rdata, (expire && owner == 1) ? 32'h0 : mem_rdata);
        chk("dm_rdata", o_dm_rdata, (expire && owner == 2) ? 32'h0 : mem_rdata);
        @(posedge i_clk);
        if (rst) begin
            owner = 0;
            age = 0;
            prefer_ic = 1;
        end else if (owner == 0) begin
            age = 0;
            if (ic_req && (!(dm_rd || dm_wen) || prefer_ic)) begin
                owner = 1;
                prefer_ic = 0;
            end else if (dm_rd || dm_wen) begin
                owner = 2;
                prefer_ic = 1;
            end
        end else if (!live || fin) begin
            owner = 0;
        end else begin
            age++;
        end
        @(negedge i_clk);
    endtask

    initial begin
        rst = 1; ic_req = 0; dm_rd = 0; dm_wen = 0; mem_ready = 0;
        ic_addr = 0; dm_addr = 0; dm_wd = 0; dm_f3 = 0; mem_rdata = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        step();
        // Tie right after reset: I-cache first, data port after one IDLE cycle
        rst = 0; ic_req = 1; ic_addr = 32'h40; dm_rd = 1; dm_addr = 32'h200; dm_f3 = 3'b010;
        mem_rdata = 32'h1234_5678;
        step();
        #1 chk("tie_first_ic", o_grant_dm, 1'b0);
        chk("tie_ic_f3", o_mem_f3, 3'b010);
        step();
        mem_ready = 1;
        #1 chk("ic_ready_pulse", o_ic_ready, 1'b1);
        step();
        ic_req = 0; mem_ready = 0;
        #1 chk("idle_gap", o_busy, 1'b0);
        step();
        mem_ready = 1;
        #1 chk("dm_second", o_grant_dm, 1'b1);
        step();
        dm_rd = 0; mem_ready = 0;
        step();
        // Write with read also asserted: write wins
        dm_wen = 1; dm_rd = 1; dm_addr = 32'h100; dm_wd = 32'hDEAD_BEEF; dm_f3 = 3'b010;
        step();
        mem_ready = 1;
        #1 chk("wr_wen", o_mem_wen, 1'b1);
        chk("wr_rd", o_mem_rd, 1'b0);
        chk("wr_wd", o_mem_wd, 32'hDEAD_BEEF);
        chk("wr_ready", o_dm_ready, 1'b1);
        step();
        dm_wen = 0; dm_rd = 0; mem_ready = 0;
        step();
        // Continuous contention alternates IC, DM, IC, DM with IDLE between
        ic_req = 1; dm_rd = 1; mem_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("alt_busy", o_busy, i % 2);
            if (i % 2 == 1) chk("alt_grant", o_grant_dm, i % 4 == 3);
            step();
        end
        ic_req = 0; dm_rd = 0; mem_ready = 0;
        step();
        // Timeout in the 4th BUSY cycle
        dm_rd = 1; mem_rdata = 32'hABCD_0123;
        repeat (4) step();
        #1 chk("to_pulse", o_timeout, 1'b1);
        chk("to_ready", o_dm_ready, 1'b1);
        chk("to_rdata", o_dm_rdata, 32'h0);
        step();
        dm_rd = 0;
        step();
        // Memory ready in that same cycle: normal completion
        dm_rd = 1;
        repeat (4) step();
        mem_ready = 1;
        #1 chk("to_beaten", o_timeout, 1'b0);
        chk("to_beaten_rdata", o_dm_rdata, 32'hABCD_0123);
        step();
        dm_rd = 0; mem_ready = 0;
        step();
        // Reset during IC_BUSY
        ic_req = 1; ic_addr = 32'h80;
        step();
        step();
        rst = 1; mem_ready = 1;
        #1 chk("rst_no_ready", o_ic_ready, 1'b0);
        step();
        rst = 0; mem_ready = 0; dm_rd = 1;
        #1 chk("rst_rd_low", o_mem_rd, 1'b0);
        chk("rst_idle", o_busy, 1'b0);
        step();
        #1 chk("rst_ic_wins", o_grant_dm, 1'b0);
        chk("rst_busy", o_busy, 1'b1);
        step();
        // Abort: requester drops mid-transfer
        ic_req = 0; dm_rd = 0; mem_ready = 1;
        #1 chk("abort_rd", o_mem_rd, 1'b0);
        chk("abort_ready", o_ic_ready, 1'b0);
        step();
        // Memory ready while IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            #1 chk("idle_ready_busy", o_busy, 1'b0);
            chk("idle_ready_dm", o_dm_ready, 1'b0);
            step();
        end
        mem_ready = 0;
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 60) == 0;
            if ($urandom_range(0, 3) == 0) ic_req = ~ic_req;
            if ($urandom_range(0, 3) == 0) dm_rd = ~dm_rd;
            if ($urandom_range(0, 5) == 0) dm_wen = ~dm_wen;
            mem_ready = $urandom_range(0, 3) == 0;
            ic_addr = $urandom; dm_addr = $urandom; dm_wd = $urandom;
            dm_f3 = 3'($urandom_range(0, 7)); mem_rdata = $urandom;
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
